// File: rtl/pixel_pkg.sv
// Purpose: shared pixel types and the write-arbiter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixel_pkg;

    // 12-bit RGB pixel, 4 bits per channel
    typedef logic [11:0] pixel_t;

    localparam pixel_t TRANSPARENT = 12'h000;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } wr_arb_state_t;

endpackage

// File: rtl/pixel_wr_arbiter_rr_picker.sv
// Purpose: combinational round-robin selector; first requester after i_last, wrapping N-1 -> 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the winner is used.
// Ports: i_req request vector, i_last previous winner, o_idx winner index, o_any any request present.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_k;

    // Scan offsets 1..N so that i_last itself has the lowest priority.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_k   = '0;
        for (int off = 1; off <= N; off++) begin
            w_k = IW'((int'(i_last) + off) % N);
            if (!o_any && i_req[w_k]) begin
                o_idx = w_k;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_wr_arbiter.sv
// Purpose: burst round-robin arbiter sharing the sprite pixel BRAM write port between loaders.
// Latency: 1 ARB cycle before first accept; accepted beat appears on wr_* 1 cycle later.
// Backpressure: in_ready is one-hot to the granted writer while the gate is open, else zero.
// Ports: clk/reset (sync, active-high); per-writer in_valid/in_last/in_add/in_data/in_ready;
//        vblank; registered wr_add/wr_data/wr_req; grant_id; busy.
// Option: define WR_BLANK_GATE_EN to only grant and accept beats while vblank is high.
module pixel_wr_arbiter
    import pixel_pkg::*;
#(
    parameter int ADD_WIDTH     = 16,
    parameter int NR_OF_WRITERS = 4,
    parameter int BURST_MAX     = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NR_OF_WRITERS-1:0]                  in_valid,
    input  logic [NR_OF_WRITERS-1:0]                  in_last,
    input  logic [NR_OF_WRITERS-1:0][ADD_WIDTH-1:0]   in_add,
    input  logic [NR_OF_WRITERS-1:0][11:0]            in_data,
    output logic [NR_OF_WRITERS-1:0]                  in_ready,
    input  logic                                      vblank,
    output logic [ADD_WIDTH-1:0]                      wr_add,
    output logic [11:0]                               wr_data,
    output logic                                      wr_req,
    output logic [$clog2(NR_OF_WRITERS)-1:0]          grant_id,
    output logic                                      busy
);

    localparam int GW = $clog2(NR_OF_WRITERS);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [NR_OF_WRITERS-1:0] ONE_HOT0 = NR_OF_WRITERS'(1);

    wr_arb_state_t          r_state;
    logic [GW-1:0]          r_last_grant;
    logic [GW-1:0]          r_grant_id;
    logic [CW-1:0]          r_beat_cnt;
    logic [ADD_WIDTH-1:0]   r_wr_add;
    pixel_t                 r_wr_data;
    logic                   r_wr_req;

    logic                   w_gate;
    logic                   w_any;
    logic [GW-1:0]          w_win;
    logic                   w_burst_open;
    logic                   w_cur_vld;
    logic                   w_accept;
    logic                   w_end_beat;

`ifdef WR_BLANK_GATE_EN
    assign w_gate = vblank;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
    assign w_gate          = 1'b1;
`endif

    rr_picker #(
        .N  (NR_OF_WRITERS),
        .IW (GW)
    ) u_picker (
        .i_req  (in_valid),
        .i_last (r_last_grant),
        .o_idx  (w_win),
        .o_any  (w_any)
    );

    // in_ready must not look at in_valid, only at state/grant/gate.
    assign w_burst_open = (r_state == BURST) && w_gate;
    assign in_ready     = w_burst_open ? (ONE_HOT0 << r_grant_id) : '0;
    assign w_cur_vld    = in_valid[r_grant_id];
    assign w_accept     = w_burst_open && w_cur_vld;
    // in_last and the BURST_MAX-th beat collapse into one end-of-burst.
    assign w_end_beat   = w_accept &&
                          (in_last[r_grant_id] || (r_beat_cnt == CW'(BURST_MAX - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB;
            r_last_grant <= GW'(NR_OF_WRITERS - 1);
            r_grant_id   <= '0;
            r_beat_cnt   <= '0;
            r_wr_add     <= '0;
            r_wr_data    <= TRANSPARENT;
            r_wr_req     <= 1'b0;
        end else begin
            r_wr_req <= w_accept;
            if (w_accept) begin
                r_wr_add  <= in_add[r_grant_id];
                r_wr_data <= in_data[r_grant_id];
            end
            case (r_state)
                ARB: begin
                    if (w_gate && w_any) begin
                        r_grant_id <= w_win;
                        r_beat_cnt <= '0;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + CW'(1);
                    end
                    // Gate closing or the writer going idle releases the grant without a beat.
                    if (!w_gate || !w_cur_vld || w_end_beat) begin
                        r_state      <= ARB;
                        r_last_grant <= r_grant_id;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign wr_add   = r_wr_add;
    assign wr_data  = r_wr_data;
    assign wr_req   = r_wr_req;
    assign grant_id = r_grant_id;
    assign busy     = (r_state == BURST);

endmodule

// File: tb/tb_pixel_wr_arbiter.sv
module tb_pixel_wr_arbiter;

    localparam int NW = 4;
    localparam int BM = 8;
    localparam int AW = 16;

    typedef struct packed {
        logic [AW-1:0] add;
        logic [11:0]   dat;
        logic          last;
    } beat_t;

    typedef struct {
        bit            req;
        int            wid;
        logic [AW-1:0] add;
        logic [11:0]   dat;
    } exp_t;

    logic                     clk;
    logic                     reset;
    logic [NW-1:0]            in_valid;
    logic [NW-1:0]            in_last;
    logic [NW-1:0][AW-1:0]    in_add;
    logic [NW-1:0][11:0]      in_data;
    logic [NW-1:0]            in_ready;
    logic                     vblank;
    logic [AW-1:0]            wr_add;
    logic [11:0]              wr_data;
    logic                     wr_req;
    logic [1:0]               grant_id;
    logic                     busy;

    beat_t dq[NW][$];
    beat_t mq[NW][$];
    exp_t  exp_q[$];
    int    n_cmp;
    int    n_err;

    pixel_wr_arbiter #(
        .ADD_WIDTH     (AW),
        .NR_OF_WRITERS (NW),
        .BURST_MAX     (BM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_add   (in_add),
        .in_data  (in_data),
        .in_ready (in_ready),
        .vblank   (vblank),
        .wr_add   (wr_add),
        .wr_data  (wr_data),
        .wr_req   (wr_req),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t mk(input logic [AW-1:0] a, input logic [11:0] d, input logic l);
        beat_t b;
        b.add  = a;
        b.dat  = d;
        b.last = l;
        return b;
    endfunction

    task automatic clear_q();
        for (int w = 0; w < NW; w++) dq[w].delete();
    endtask

    task automatic drive_inputs();
        beat_t b;
        for (int w = 0; w < NW; w++) begin
            if (dq[w].size() > 0) begin
                b = dq[w][0];
                in_valid[w] = 1'b1;
                in_add[w]   = b.add;
                in_data[w]  = b.dat;
                in_last[w]  = b.last;
            end else begin
                in_valid[w] = 1'b0;
                in_last[w]  = 1'b0;
            end
        end
    endtask

    task automatic pop_hs(input logic [NW-1:0] hs);
        beat_t b;
        for (int w = 0; w < NW; w++) begin
            if (hs[w] && dq[w].size() > 0) b = dq[w].pop_front();
        end
    endtask

    // Transaction-level expectation: round-robin bursts, each preceded by one ARB slot,
    // cut by last / BURST_MAX, and costing one empty slot when the writer runs dry.
    task automatic build_model();
        int    lg;
        int    w;
        int    n;
        bit    done;
        bit    fin;
        beat_t b;
        exp_t  e;
        lg = NW - 1;
        fin = 0;
        exp_q.delete();
        for (int i = 0; i < NW; i++) mq[i] = dq[i];
        for (int guard = 0; guard < 500 && !fin; guard++) begin
            w = -1;
            for (int o = 1; o <= NW; o++)
                if (w < 0 && mq[(lg + o) % NW].size() > 0) w = (lg + o) % NW;
            if (w < 0) begin
                fin = 1;
            end else begin
                e = '{req: 0, wid: 0, add: '0, dat: '0};
                exp_q.push_back(e);
                n = 0;
                done = 0;
                while (!done) begin
                    if (mq[w].size() == 0) begin
                        exp_q.push_back(e);
                        done = 1;
                    end else begin
                        b = mq[w].pop_front();
                        exp_q.push_back('{req: 1, wid: w, add: b.add, dat: b.dat});
                        n++;
                        done = b.last || (n == BM);
                    end
                end
                lg = w;
            end
        end
    endtask

    task automatic run_scen(input string name);
        logic [NW-1:0] hs;
        exp_t e;
        int   left;
        build_model();
        for (int k = 0; k < exp_q.size() + 3; k++) begin
            drive_inputs();
            #1;
            hs = in_valid & in_ready;
            chk({name, "_rdy_1hot"}, {31'b0, $onehot0(in_ready)}, 32'd1);
            @(posedge clk);
            pop_hs(hs);
            @(negedge clk);
            if (k < exp_q.size()) begin
                e = exp_q[k];
                chk({name, "_wr_req"}, {31'b0, wr_req}, {31'b0, e.req});
                if (e.req) begin
                    chk({name, "_wr_add"}, {16'b0, wr_add}, {16'b0, e.add});
                    chk({name, "_wr_data"}, {20'b0, wr_data}, {20'b0, e.dat});
                    chk({name, "_grant"}, {30'b0, grant_id}, e.wid);
                end
            end else begin
                chk({name, "_tail_wr_req"}, {31'b0, wr_req}, 32'd0);
            end
        end
        left = 0;
        for (int w = 0; w < NW; w++) left += dq[w].size();
        chk({name, "_drained"}, left, 32'd0);
    endtask

    task automatic do_reset();
        clear_q();
        in_valid = '0;
        in_last  = '0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_wr_req", {31'b0, wr_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {28'b0, in_ready}, 32'd0);
        chk("rst_grant", {30'b0, grant_id}, 32'd0);
        chk("rst_wr_add", {16'b0, wr_add}, 32'd0);
        chk("rst_wr_data", {20'b0, wr_data}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic reset_mid_burst();
        int acc;
        bit hit;
        logic [NW-1:0] hs;
        acc = 0;
        hit = 0;
        for (int i = 0; i < 8; i++) dq[2].push_back(mk(16'h0200 + 16'(i), 12'(i + 1), 1'b0));
        for (int c = 0; c < 20 && !hit; c++) begin
            drive_inputs();
            #1;
            hs = in_valid & in_ready;
            if (hs != 0) begin
                acc++;
                if (acc == 4) begin
                    reset = 1'b1;
                    hit = 1;
                end
            end
            @(posedge clk);
            pop_hs(hs);
            @(negedge clk);
        end
        chk("midrst_reached", {31'b0, hit}, 32'd1);
        chk("midrst_wr_req", {31'b0, wr_req}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_ready", {28'b0, in_ready}, 32'd0);
        chk("midrst_grant", {30'b0, grant_id}, 32'd0);
        reset = 1'b0;
        clear_q();
        dq[2].push_back(mk(16'h0300, 12'h0AB, 1'b1));
        dq[0].push_back(mk(16'h0400, 12'h0CD, 1'b1));
        run_scen("after_rst");
    endtask

`ifdef WR_BLANK_GATE_EN
    task automatic gate_test();
        logic [NW-1:0] hs;
        for (int i = 0; i < 4; i++) dq[0].push_back(mk(16'h0500 + 16'(i), 12'h0F0, i == 3));
        vblank = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive_inputs();
            #1;
            chk("gate_closed_rdy", {28'b0, in_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("gate_closed_wr_req", {31'b0, wr_req}, 32'd0);
            chk("gate_closed_busy", {31'b0, busy}, 32'd0);
        end
        vblank = 1'b1;
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        chk("gate_open_busy", {31'b0, busy}, 32'd1);
        drive_inputs();
        #1;
        hs = in_valid & in_ready;
        chk("gate_open_rdy", {28'b0, in_ready}, 32'd1);
        @(posedge clk);
        pop_hs(hs);
        @(negedge clk);
        chk("gate_beat_wr_req", {31'b0, wr_req}, 32'd1);
        chk("gate_beat_wr_add", {16'b0, wr_add}, 32'h0500);
        vblank = 1'b0;
        drive_inputs();
        #1;
        chk("gate_fall_rdy", {28'b0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("gate_cut_wr_req", {31'b0, wr_req}, 32'd0);
        chk("gate_cut_busy", {31'b0, busy}, 32'd0);
        vblank = 1'b1;
    endtask
`endif

    initial begin
        beat_t b;
        int    npk;
        int    len;
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        vblank   = 1'b1;
        in_valid = '0;
        in_last  = '0;
        in_add   = '0;
        in_data  = '0;

        // Lone writer 1, three beats ending on last.
        do_reset();
        for (int i = 0; i < 3; i++) dq[1].push_back(mk(16'h0010 + 16'(i), 12'hF00, i == 2));
        run_scen("solo_w1");

        // All writers streaming with no last: BURST_MAX forces rotation 0,1,2,3,0,...
        do_reset();
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < 2 * BM; i++)
                dq[w].push_back(mk(16'(w * 256 + i), 12'(w * 16 + i), 1'b0));
        run_scen("rr_full");

        // Writer 2 runs dry after 2 beats without last; writer 3 follows.
        do_reset();
        dq[2].push_back(mk(16'h0020, 12'h111, 1'b0));
        dq[2].push_back(mk(16'h0021, 12'h222, 1'b0));
        for (int i = 0; i < 3; i++) dq[3].push_back(mk(16'h0030 + 16'(i), 12'h333, i == 2));
        run_scen("w2_drop");

        // in_last on the BURST_MAX-th beat rotates exactly once.
        do_reset();
        for (int i = 0; i < 2 * BM; i++)
            dq[0].push_back(mk(16'h0040 + 16'(i), 12'h0A0, (i == BM - 1) || (i == 2 * BM - 1)));
        dq[1].push_back(mk(16'h0060, 12'h0B0, 1'b0));
        dq[1].push_back(mk(16'h0061, 12'h0B1, 1'b1));
        run_scen("last_at_max");

        do_reset();
        reset_mid_burst();

`ifdef WR_BLANK_GATE_EN
        do_reset();
        gate_test();
`endif

        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int w = 0; w < NW; w++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 12);
                    for (int i = 0; i < len; i++)
                        dq[w].push_back(mk(16'($urandom), 12'($urandom), i == len - 1));
                end
                if (dq[w].size() > 0 && $urandom_range(0, 3) == 0) begin
                    b = dq[w].pop_back();
                    b.last = 1'b0;
                    dq[w].push_back(b);
                end
            end
            run_scen("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
